// File: rtl/bp_pkg.sv
// Shared static-prediction decode for LA32R direct branches.
// The fetch-side predictor and the backend BRU both use bp_predict.
package bp_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 3;

  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h16;
  localparam logic [5:0] OP_BNE  = 6'h17;
  localparam logic [5:0] OP_BLT  = 6'h18;
  localparam logic [5:0] OP_BGE  = 6'h19;
  localparam logic [5:0] OP_BLTU = 6'h1A;
  localparam logic [5:0] OP_BGEU = 6'h1B;

  typedef enum logic {ST_IDLE, ST_WAIT} bp_state_t;

  typedef struct packed {
    logic            is_branch;
    logic            is_cond;
    logic            is_call;
    logic            is_ret;
    logic            redirect;
    logic [XLEN-1:0] offset;
  } bp_decode_t;

  typedef struct packed {
    logic            redirect;
    logic [XLEN-1:0] target;
  } bp_pred_t;

  // Conditional branches follow backward-taken / forward-not-taken.
  function automatic bp_decode_t bp_decode(input logic [31:0] inst);
    bp_decode_t  d;
    logic [15:0] offs16;
    logic [25:0] offs26;
    offs16 = inst[25:10];
    offs26 = {inst[9:0], inst[25:10]};
    d      = '0;
    case (inst[31:26])
      OP_JIRL: begin
        d.is_branch = 1'b1;
        d.is_ret    = (inst[4:0] == 5'd0) && (inst[9:5] == 5'd1);
        d.offset    = {{14{offs16[15]}}, offs16, 2'b00};
      end
      OP_B, OP_BL: begin
        d.is_branch = 1'b1;
        d.is_call   = (inst[31:26] == OP_BL);
        d.redirect  = 1'b1;
        d.offset    = {{4{offs26[25]}}, offs26, 2'b00};
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        d.is_branch = 1'b1;
        d.is_cond   = 1'b1;
        d.redirect  = offs16[15];
        d.offset    = {{14{offs16[15]}}, offs16, 2'b00};
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  // JIRL never predicts here; return prediction comes from the RAS.
  function automatic bp_pred_t bp_predict(input logic [31:0] inst, input logic [31:0] pc);
    bp_decode_t d;
    bp_pred_t   p;
    d          = bp_decode(inst);
    p.redirect = d.redirect;
    p.target   = pc + d.offset;
    return p;
  endfunction

  function automatic logic bp_is_call(input logic [31:0] inst);
    bp_decode_t d;
    d = bp_decode(inst);
    return d.is_call;
  endfunction

  function automatic logic bp_is_ret(input logic [31:0] inst);
    bp_decode_t d;
    d = bp_decode(inst);
    return d.is_ret;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack; the oldest entry is overwritten when full.
// Only built when STATIC_BP_RAS_EN is defined.
`ifdef STATIC_BP_RAS_EN
module bp_ras
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_addr_i,
  input  logic            pop_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned RCNT_W = PTR_W + 1;

  logic [XLEN-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  top_idx;
  logic [RCNT_W-1:0] cnt_q;

  assign top_idx = ptr_q - PTR_W'(1);
  assign top_o   = mem_q[top_idx];
  assign empty_o = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[ptr_q] <= push_addr_i;
      ptr_q        <= ptr_q + PTR_W'(1);
      if (cnt_q != RCNT_W'(DEPTH)) cnt_q <= cnt_q + RCNT_W'(1);
    end else if (pop_i && !empty_o) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - RCNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/static_branch_predictor.sv
// Fetch-side static branch predictor: stalls fetch and issues a redirect target.
// Define STATIC_BP_RAS_EN to add a return-address stack for JIRL returns.
module static_branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned TARGET_DELAY = 1,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inst_valid_i,
  input  logic [31:0] fetch_inst_i,
  input  logic [31:0] fetch_inst_pc_i,
  output logic        fetch_flush_o,
  output logic        fetch_target_valid_o,
  output logic [31:0] fetch_target_pc_o,
  input  logic        flush_all_i
);

  if (TARGET_DELAY < 1 || TARGET_DELAY > 7) begin : g_bad_delay
    $error("TARGET_DELAY out of range 1..7");
  end
  if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras
    $error("RAS_DEPTH must be a power of two in 2..16");
  end

  bp_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  target_q, target_d;

  bp_pred_t        pred;
  logic            accept;
  logic            redirect;
  logic            take;
  logic [XLEN-1:0] redir_target;

  assign pred   = bp_predict(fetch_inst_i, fetch_inst_pc_i);
  assign accept = fetch_inst_valid_i && (state_q == ST_IDLE) && !flush_all_i && !rst;

`ifdef STATIC_BP_RAS_EN
  logic            ras_empty;
  logic [XLEN-1:0] ras_top;
  logic            ras_pop;

  assign ras_pop = accept && bp_is_ret(fetch_inst_i) && !ras_empty;

  bp_ras #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst        (rst),
    .push_i     (accept && bp_is_call(fetch_inst_i)),
    .push_addr_i(fetch_inst_pc_i + 32'd4),
    .pop_i      (ras_pop),
    .top_o      (ras_top),
    .empty_o    (ras_empty)
  );

  assign redirect     = pred.redirect || ras_pop;
  assign redir_target = ras_pop ? ras_top : pred.target;
`else
  assign redirect     = pred.redirect;
  assign redir_target = pred.target;
`endif

  assign take = accept && redirect;

  // WAIT counts down the remaining stall cycles before the target strobe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    if (flush_all_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            state_d  = ST_WAIT;
            cnt_d    = CNT_W'(TARGET_DELAY - 1);
            target_d = redir_target;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  assign fetch_flush_o        = !rst && !flush_all_i &&
                                (take || (state_q == ST_WAIT && cnt_q != '0));
  assign fetch_target_valid_o = !rst && !flush_all_i && (state_q == ST_WAIT) && (cnt_q == '0);
  assign fetch_target_pc_o    = target_q;

endmodule
